ffs_iter_m: RTL

//  Set-bit iterator built around the find-first-set priority encoder.
//  - Accepts a request/flag vector over a valid/ready handshake and registers it.
//  - Emits the index of every set bit, one per output handshake, clearing each bit as it is consumed.
//  - Sits directly downstream of request collection and converts a bit-vector into an index stream
//    for grant/dispatch logic.

---
 rtl/ffs_iter_m.sv | 82 ++++++++
 1 files changed

// File: rtl/ffs_iter_m.sv
// rtl/ffs_iter_m.sv - set-bit iterator: registers a vector, emits one set-bit index per handshake.
// Optional out_last port (final index of each vector) enabled by defining FFS_ITER_LAST_EN.
module ffs_iter_m #(
  parameter  int INPUT_WIDTH  = 8,
  parameter  int SIDE         = 0,
  localparam int OUTPUT_WIDTH = $clog2((INPUT_WIDTH > 2) ? INPUT_WIDTH : 2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_index,
  output logic                    busy
`ifdef FFS_ITER_LAST_EN
  , output logic                  out_last
`endif
);

  logic [INPUT_WIDTH-1:0]  vec_q, vec_d;
  logic [INPUT_WIDTH-1:0]  sel;
  logic [OUTPUT_WIDTH-1:0] idx;
  logic                    last;
  logic                    in_fire, out_fire;

  // Later matches overwrite earlier ones, so scan order decides which end wins.
  always_comb begin
    idx = '0;
    sel = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (SIDE == 0) begin
        if (vec_q[i]) begin
          idx    = OUTPUT_WIDTH'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end else begin
        if (vec_q[INPUT_WIDTH-1-i]) begin
          idx                  = OUTPUT_WIDTH'(INPUT_WIDTH-1-i);
          sel                  = '0;
          sel[INPUT_WIDTH-1-i] = 1'b1;
        end
      end
    end
  end

  assign busy      = (vec_q != '0);
  assign last      = busy && ((vec_q & (vec_q - INPUT_WIDTH'(1))) == '0);
  assign out_valid = busy;
  assign out_index = out_valid ? idx : '0;
  assign out_fire  = out_valid & out_ready;
  // Refill is allowed in the same cycle the final bit is popped, never during a flush.
  assign in_ready  = ~flush & (~busy | (out_fire & last));
  assign in_fire   = in_valid & in_ready;

`ifdef FFS_ITER_LAST_EN
  assign out_last  = out_valid & last;
`endif

  always_comb begin
    vec_d = vec_q;
    if (flush) begin
      vec_d = '0;
    end else if (in_fire) begin
      vec_d = in_data;
    end else if (out_fire) begin
      vec_d = vec_q & ~sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

endmodule
